axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
AXI4 slave that terminates one port of the bus fabric and drives a single-port synchronous SRAM used as instruction or data memory. It consumes the transactions the CPU-side masters produce, which have 4-bit master IDs widened by the interconnect. It serves one transaction at a time, either read or write, with read/write arbitration, INCR/FIXED bursts up to 16 beats, and byte-strobed writes.

Parameters:
ID_W, 8, width of AWID/ARID/BID/RID (master ID plus interconnect tag)
ADDR_W, 14, SRAM word-address width (depth = 2^ADDR_W words of 32 bits)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/32/4/3/2  write address
AWVALID in 1, AWREADY out 1  write address handshake
WDATA/WSTRB/WLAST  in  32/4/1  write data
WVALID in 1, WREADY out 1  write data handshake
BID/BRESP  out  ID_W/2  write response
BVALID out 1, BREADY in 1  write response handshake
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/32/4/3/2  read address
ARVALID in 1, ARREADY out 1  read address handshake
RID/RDATA/RRESP/RLAST  out  ID_W/32/2/1  read data
RVALID out 1, RREADY in 1  read data handshake
sram_cs  out  1  SRAM chip select, one access per cycle
sram_we  out  4  byte write enables (0 = read)
sram_addr  out  ADDR_W  word address = AxADDR[ADDR_W+1:2]
sram_di  out  32  write data
sram_do  in  32  read data, valid the cycle after a read access and held until the next access

Behaviour:
- Reset (async, immediate, also mid-burst): state IDLE; all READY/VALID low; BID/RID/RDATA 0; BRESP/RRESP OKAY; RLAST 0; sram_cs 0, sram_we 0; arbiter priority = read. No response is ever issued for an aborted burst.
- FSM: IDLE, R_REQ, R_DATA, W_DATA, W_RESP.
- IDLE: AWREADY/ARREADY combinational, only the granted channel is ready. Only one valid: grant it. Both valid: grant the channel not granted last (round-robin flag, updated on each grant).
- AR handshake: latch ID, word address, beats = ARLEN+1, burst type; go to R_REQ.
- R_REQ (1 cycle): sram_cs=1, sram_we=0; go to R_DATA.
- R_DATA: RVALID=1, RDATA=sram_do, RID=latched ID, RLAST=(remaining==1). Hold every R output stable while RREADY=0; no SRAM access while waiting. On handshake: last beat goes to IDLE, else advance address and go to R_REQ. Read throughput is 1 beat per 2 cycles. First RVALID is 2 cycles after the AR handshake.
- AW handshake: latch ID, address, beats, burst type; go to W_DATA.
- W_DATA: WREADY=1. On W handshake, same cycle: sram_cs=1, sram_we=WSTRB, sram_di=WDATA. Beats after AWLEN+1 are accepted but their SRAM write is suppressed. WLAST handshake goes to W_RESP.
- WLAST on a beat other than beat AWLEN+1 sets a sticky error, and BRESP=SLVERR (2'b10). An early WLAST ends the burst.
- W_RESP: BVALID=1, BID=latched ID, held until BREADY, then IDLE.
- Address update: INCR (01) adds 1 word, modulo 2^ADDR_W. FIXED (00) does not change the address. WRAP/reserved are treated as INCR.
- AxSIZE is ignored; all beats are 32-bit. Address bits [1:0] are ignored.
- Channels are not serviced concurrently. An AR arriving during a write waits, with ARREADY low.

Optional Feature:
- Macro SRAM_SLV_RANGE_CHK_EN.
- Defined: any beat whose byte address is at or above 4*2^ADDR_W (computed on the full 32-bit running address) suppresses its SRAM access. On a read, RDATA=0 and RRESP=DECERR (2'b11) for that beat. On a write, BRESP=DECERR, which overrides SLVERR.
- Not defined: upper address bits are ignored, so memory aliases, and responses are always OKAY except the WLAST SLVERR.

Test Plan:
- Single write, then read: AW at 0x10, WDATA=0xDEADBEEF, WSTRB=4'b0101, SRAM preloaded 0x11223344 -> sram_we=0101 at word 4, BRESP=OKAY. Read of 0x10 returns RDATA=0x11AD33EF, RLAST=1, RVALID 2 cycles after AR handshake.
- 4-beat INCR read at 0x100, RREADY low for 3 cycles on beat 2 -> RDATA/RID/RLAST held stable. Words 0x40..0x43 are returned in order, RLAST only on beat 4, and no sram_cs while stalled.
- AWVALID and ARVALID both high from reset, each asserted three times back-to-back -> grants alternate R,W,R,W,R,W.
- Write with AWLEN=3 and WLAST on beat 2 -> 2 SRAM writes, BRESP=SLVERR. With AWLEN=1 and 4 beats: 2 writes, beats 3-4 suppressed, BRESP=SLVERR.
- FIXED 3-beat write to 0x20 with data 1,2,3 -> word 8 = 3. A FIXED 2-beat read returns 3,3.
- ARESET pulsed mid 8-beat read after beat 3 -> RVALID drops immediately and the FSM is in IDLE. The next read completes correctly with the arbiter at read priority. With SRAM_SLV_RANGE_CHK_EN, ADDR_W=14: a read at 0x10000 gives RRESP=DECERR, RDATA=0, no sram_cs.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between a master and axi_sram_slave.
// Upper-case signal names follow the AXI channel naming.
interface axi_sram_slave_if #(
  parameter int ID_W = 8
);
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;

  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;

  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;

  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave onto a 32-bit single-port SRAM, one burst at a time; reads 1 beat / 2 cycles, writes 1 beat/cycle.
// Stalls on RREADY/BREADY hold all outputs; SRAM_SLV_RANGE_CHK_EN adds DECERR for out-of-range beats.
module axi_sram_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 14
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_sram_slave_if.slave   axi,
  output logic              sram_cs,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  typedef enum logic [2:0] {IDLE, R_REQ, R_DATA, W_DATA, W_RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] id_q;
  logic [29:0]     addr_q;     // running word address, full width for range checks
  logic [29:0]     addr_nxt;
  logic [4:0]      beats_q;    // beats still owed to the SRAM in this burst
  logic            fixed_q;
  logic            slverr_q;
  logic            decerr_q;
  logic            prio_rd_q;  // read wins the next tie
  logic            grant_r;
  logic            grant_w;
  logic            oor;
  logic            rd_phase;
  logic            unused_bits;

  assign addr_nxt = fixed_q ? addr_q : addr_q + 30'd1;

`ifdef SRAM_SLV_RANGE_CHK_EN
  assign oor = (addr_q[29:ADDR_W] != '0);
`else
  assign oor = 1'b0;
`endif

  assign unused_bits = ^{axi.AWSIZE, axi.ARSIZE, axi.AWADDR[1:0], axi.ARADDR[1:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant_r     = 1'b0;
    grant_w     = 1'b0;
    axi.AWREADY = 1'b0;
    axi.ARREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.RVALID  = 1'b0;
    sram_cs     = 1'b0;
    sram_we     = 4'b0000;
    sram_addr   = addr_q[ADDR_W-1:0];
    sram_di     = axi.WDATA;
    case (state_q)
      IDLE: begin
        grant_r     = axi.ARVALID && (!axi.AWVALID || prio_rd_q);
        grant_w     = axi.AWVALID && !grant_r;
        axi.ARREADY = grant_r;
        axi.AWREADY = grant_w;
        if (grant_r)      state_d = R_REQ;
        else if (grant_w) state_d = W_DATA;
      end
      R_REQ: begin
        sram_cs = !oor;
        state_d = R_DATA;
      end
      R_DATA: begin
        axi.RVALID = 1'b1;
        if (axi.RREADY) state_d = (beats_q == 5'd1) ? IDLE : R_REQ;
      end
      W_DATA: begin
        axi.WREADY = 1'b1;
        if (axi.WVALID) begin
          // beats beyond AWLEN+1 are swallowed without touching the SRAM
          if (beats_q != 5'd0 && !oor) begin
            sram_cs = 1'b1;
            sram_we = axi.WSTRB;
          end
          if (axi.WLAST) state_d = W_RESP;
        end
      end
      W_RESP: begin
        axi.BVALID = 1'b1;
        if (axi.BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      id_q      <= '0;
      addr_q    <= '0;
      beats_q   <= '0;
      fixed_q   <= 1'b0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      prio_rd_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_r) begin
            id_q      <= axi.ARID;
            addr_q    <= axi.ARADDR[31:2];
            beats_q   <= {1'b0, axi.ARLEN} + 5'd1;
            fixed_q   <= (axi.ARBURST == 2'b00);
            prio_rd_q <= 1'b0;
          end else if (grant_w) begin
            id_q      <= axi.AWID;
            addr_q    <= axi.AWADDR[31:2];
            beats_q   <= {1'b0, axi.AWLEN} + 5'd1;
            fixed_q   <= (axi.AWBURST == 2'b00);
            slverr_q  <= 1'b0;
            decerr_q  <= 1'b0;
            prio_rd_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (axi.RREADY) begin
            beats_q <= beats_q - 5'd1;
            addr_q  <= addr_nxt;
          end
        end
        W_DATA: begin
          if (axi.WVALID) begin
            if (beats_q != 5'd0) begin
              beats_q <= beats_q - 5'd1;
              addr_q  <= addr_nxt;
              if (oor) decerr_q <= 1'b1;
            end
            if (axi.WLAST && beats_q != 5'd1) slverr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_phase  = (state_q == R_DATA);
  assign axi.RID   = rd_phase ? id_q : '0;
  assign axi.RDATA = (rd_phase && !oor) ? sram_do : 32'h0;
  assign axi.RRESP = (rd_phase && oor) ? 2'b11 : 2'b00;
  assign axi.RLAST = rd_phase && (beats_q == 5'd1);
  assign axi.BID   = (state_q == W_RESP) ? id_q : '0;
  assign axi.BRESP = (state_q != W_RESP) ? 2'b00 :
                     decerr_q            ? 2'b11 :
                     slverr_q            ? 2'b10 : 2'b00;

endmodule
